fmul_share_arbiter: RTL and testbench
=====================================

Name: fmul_share_arbiter

Overview:
- Shares one combinational single-precision float multiplier between N_REQ requesters.
- Uses round-robin arbitration with a valid/ready handshake on each requester and on the single tagged response port.
- Operands and results are registered around the multiplier, so its combinational path sits between two flop stages.
- Sits between the vector/control front-end and the float multiplier in the CA datapath.

Parameters:
- N_REQ, 4, number of requesters; legal values are 2 to 16.
- ID_W, $clog2(N_REQ), width of the requester tag.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand-valid.
- req_a  in  32*N_REQ  operand A; requester i drives bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, packed the same way as req_a.
- req_ready  out  N_REQ  one-hot accept; at most one bit is high in any cycle.
- resp_valid  out  1  result available.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_result  out  32  IEEE-754 single product.
- resp_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to IDLE and the priority pointer goes to 0.
  - req_ready = 0, resp_valid = 0, resp_id = 0, resp_result = 0.
  - The operand registers are cleared.
  - Any in-flight transaction is dropped and no response is produced for it.
- State machine, with three states IDLE, CALC and RESP:
  - IDLE:
    - req_ready[g] = 1 combinationally, where g is the first i with req_valid[i] = 1, scanning from ptr, ptr+1, ... and wrapping at N_REQ.
    - If no request is valid, req_ready = 0.
    - A handshake (req_valid[g] & req_ready[g]) latches req_a[g], req_b[g] and g into the operand and tag registers.
    - On a handshake, ptr <= (g+1) mod N_REQ and the state goes to CALC.
  - CALC:
    - req_ready = 0.
    - The multiplier evaluates the registered operands.
    - At the clock edge the product goes into resp_result, the tag goes into resp_id, and the state goes to RESP.
  - RESP:
    - resp_valid = 1 and req_ready = 0.
    - resp_result and resp_id stay stable while resp_ready = 0. There is no timeout.
    - When resp_valid & resp_ready, the state goes to IDLE and resp_valid drops in the next cycle.
- Latency and throughput:
  - Handshake in cycle T gives resp_valid high in cycle T+2 if resp_ready is already high.
  - Maximum throughput is one product every 3 cycles.
- ptr changes only on an accepted request. Requesters that are valid but not granted are never starved: with all N_REQ valid, each is granted once in every N_REQ grants.
- Requesters may drop req_valid without a handshake. Nothing is retained for them and ptr does not change.
- Arithmetic follows the multiplier's rules:
  - Sign is the XOR of the operand signs.
  - The exponent is re-biased.
  - The 48-bit significand product is normalised by a 1-bit shift, and the result is truncated with no rounding.
  - If either operand is exactly 0x00000000, the result is 0x00000000.
  - NaN, Inf, denormals and over/underflow are not handled; results for these inputs are unspecified, and the bench must not check them.
- Simultaneous events:
  - rst has priority over everything.
  - A new request arriving in the same cycle as a RESP handshake is not granted until the following IDLE cycle.

Decomposition:
- Shared package fp_pkg holds:
  - FP_W = 32, EXP_W = 8, MAN_W = 23, EXP_BIAS = 127;
  - typedef fp32_t;
  - an enum arb_state_t {IDLE, CALC, RESP}.
- Sub-module rr_grant (parameter N) is combinational: inputs req[N] and ptr; output one-hot grant and index.
- The team's existing combinational float multiplier is instantiated once as the shared resource.

Test Plan:
- Single request: req_valid = 0001, a = 0x40000000 (2.0), b = 0x40400000 (3.0), resp_ready = 1 → req_ready = 0001 in the same cycle; resp_valid high 2 cycles later with resp_id = 0 and resp_result = 0x40C00000.
- All four valid and held, with per-requester operands 0x3FC00000 × 0x3FC00000 → grants come out in order 0, 1, 2, 3, 0; every result is 0x40100000 (2.25) with the matching resp_id, one result every 3 cycles.
- Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid → resp_valid, resp_id and resp_result stay stable and req_ready stays 0; after resp_ready = 1 for one cycle, resp_valid goes to 0 and a new grant issues in the next cycle.
- Sign and zero: 0xC0000000 × 0x40400000 gives 0xC0C00000; 0x00000000 × 0x40400000 gives 0x00000000.
- Reset in CALC: pulse rst for one cycle while a product is in flight → no response appears, all outputs are 0, and the next request from requester 2 is granted as if ptr = 0.
- Fairness with a gap: requester 1 is granted, then only requesters 0 and 3 are valid → requester 3 is granted first (ptr = 2), then requester 0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared float-format constants, the fp32 word type and the arbiter state encoding.
package fp_pkg;
  localparam int FP_W     = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  typedef logic [FP_W-1:0] fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } arb_state_t;
endpackage

// File: rtl/fmul_share_arbiter_if.sv
// Request/response bundle between the requesters, the shared multiplier arbiter and the result consumer.
interface fmul_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                resp_valid;
  logic [ID_W-1:0]     resp_id;
  logic [31:0]         resp_result;
  logic                resp_ready;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result
  );
endinterface

// File: rtl/fp_mul.sv
// Combinational single-precision multiplier: re-biased exponent, 1-bit normalise, truncation, zero shortcut.
module fp_mul
  import fp_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output fp32_t p_o
);
  localparam int PW = 2 * (MAN_W + 1);

  logic [PW-1:0]    prod;
  logic [PW-1:0]    norm;
  logic [EXP_W+1:0] exp_sum;
  logic             sign;

  assign sign = a_i[FP_W-1] ^ b_i[FP_W-1];
  assign prod = PW'({1'b1, a_i[MAN_W-1:0]}) * PW'({1'b1, b_i[MAN_W-1:0]});

  // Product of two [1,2) significands lies in [1,4); the top bit says which half.
  assign norm    = prod[PW-1] ? prod : (prod << 1);
  assign exp_sum = (EXP_W+2)'(a_i[FP_W-2:MAN_W]) + (EXP_W+2)'(b_i[FP_W-2:MAN_W])
                 + (EXP_W+2)'(prod[PW-1]) - (EXP_W+2)'(EXP_BIAS);

  always_comb begin
    if (a_i == '0 || b_i == '0) begin
      p_o = '0;
    end else begin
      p_o = {sign, EXP_W'(exp_sum), MAN_W'(norm >> (MAN_W + 1))};
    end
  end
endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping at N.
module rr_grant #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] pos_idx [N];
  logic [N-1:0]  rot_req;

  // rot_req[k] is the request seen k places after the pointer.
  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0] sum;
    assign sum          = {1'b0, ptr_i} + (IW+1)'(gi);
    assign pos_idx[gi]  = IW'((sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum);
    assign rot_req[gi]  = req_i[pos_idx[gi]];
  end

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        any_o = 1'b1;
        idx_o = pos_idx[k];
      end
    end
  end

  always_comb begin
    grant_o = '0;
    if (any_o) grant_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/fmul_share_arbiter.sv
// Round-robin sharing of one float multiplier among N_REQ requesters with a tagged, back-pressured response.
module fmul_share_arbiter
  import fp_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst,
  fmul_share_arbiter_if.slave bus
);
  arb_state_t      state_q;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] tag_q;
  fp32_t           a_q;
  fp32_t           b_q;
  fp32_t           resp_result_q;
  logic [ID_W-1:0] resp_id_q;
  logic            resp_valid_q;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  fp32_t            op_a [N_REQ];
  fp32_t            op_b [N_REQ];
  fp32_t            product;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
    assign op_a[gi] = bus.req_a[32*gi +: 32];
    assign op_b[gi] = bus.req_b[32*gi +: 32];
  end

  rr_grant #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr_grant (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  fp_mul u_fp_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (product)
  );

  // Grant is only offered while idle, so a request arriving with a RESP handshake waits a cycle.
  assign bus.req_ready   = (state_q == IDLE) ? grant : '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      tag_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      resp_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            a_q     <= op_a[grant_idx];
            b_q     <= op_b[grant_idx];
            tag_q   <= grant_idx;
            ptr_q   <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            state_q <= CALC;
          end
        end
        CALC: begin
          resp_result_q <= product;
          resp_id_q     <= tag_q;
          resp_valid_q  <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fmul_share_arbiter.sv
// Directed bench for fmul_share_arbiter: grant order, latency, backpressure, arithmetic and reset behaviour.
module tb_fmul_share_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  fmul_share_arbiter_if #(.N_REQ(4), .ID_W(2)) bus ();

  fmul_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    tests++; if (bus.req_ready !== 4'b0000) begin failed++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    tests++; if (bus.resp_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got=%b exp=0", bus.resp_valid); end
    tests++; if (bus.resp_id !== 2'd0) begin failed++; $display("FAIL reset_id got=%0d exp=0", bus.resp_id); end
    tests++; if (bus.resp_result !== 32'h0) begin failed++; $display("FAIL reset_result got=%h exp=0", bus.resp_result); end
    rst = 1'b0;
    $display("[TB] reset: outputs idle");
  endtask

  task automatic test_single();
    set_ops(0, 32'h40000000, 32'h40400000);
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 4'b0001) begin failed++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin failed++; $display("FAIL single_calc valid=%b ready=%b exp valid=0 ready=0000", bus.resp_valid, bus.req_ready); end
    tick();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_result !== 32'h40C00000) begin failed++; $display("FAIL single_resp valid=%b id=%0d res=%h exp 1/0/40c00000", bus.resp_valid, bus.resp_id, bus.resp_result); end
    tick();
    tests++; if (bus.resp_valid !== 1'b0) begin failed++; $display("FAIL single_drop got=%b exp=0", bus.resp_valid); end
    $display("[TB] single: 2.0 x 3.0 -> id=%0d res=%h", 0, 32'h40C00000);
  endtask

  task automatic test_round_robin();
    int exp_id;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_ops(i, 32'h3FC00000, 32'h3FC00000);
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_id = k % 4;
      #1;
      tests++; if (bus.req_ready !== 4'(1 << exp_id)) begin failed++; $display("FAIL rr_grant%0d got=%b exp=%b", k, bus.req_ready, 4'(1 << exp_id)); end
      tick();
      tests++; if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b0) begin failed++; $display("FAIL rr_calc%0d ready=%b valid=%b exp 0000/0", k, bus.req_ready, bus.resp_valid); end
      tick();
      tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(exp_id) || bus.resp_result !== 32'h40100000) begin failed++; $display("FAIL rr_resp%0d valid=%b id=%0d res=%h exp 1/%0d/40100000", k, bus.resp_valid, bus.resp_id, bus.resp_result, exp_id); end
      $display("[TB] rr: grant %0d id=%0d res=%h", k, bus.resp_id, bus.resp_result);
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    set_ops(1, 32'hC0000000, 32'h40400000);
    set_ops(2, 32'h00000000, 32'h40400000);
    bus.req_valid  = 4'b0010;
    bus.resp_ready = 1'b0;
    #1;
    tests++; if (bus.req_ready !== 4'b0010) begin failed++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b0100;
    tick();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_result !== 32'hC0C00000) begin failed++; $display("FAIL bp_sign valid=%b id=%0d res=%h exp 1/1/c0c00000", bus.resp_valid, bus.resp_id, bus.resp_result); end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_result !== 32'hC0C00000 || bus.req_ready !== 4'b0000) begin failed++; $display("FAIL bp_hold%0d valid=%b id=%0d res=%h ready=%b exp 1/1/c0c00000/0000", k, bus.resp_valid, bus.resp_id, bus.resp_result, bus.req_ready); end
    end
    bus.resp_ready = 1'b1;
    tick();
    tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin failed++; $display("FAIL bp_release valid=%b ready=%b exp 0/0100", bus.resp_valid, bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_result !== 32'h00000000) begin failed++; $display("FAIL bp_zero valid=%b id=%0d res=%h exp 1/2/00000000", bus.resp_valid, bus.resp_id, bus.resp_result); end
    $display("[TB] backpressure: held 5 cycles, then zero product id=%0d res=%h", bus.resp_id, bus.resp_result);
    tick();
  endtask

  task automatic test_reset_calc();
    set_ops(2, 32'h40000000, 32'h40400000);
    set_ops(3, 32'h3FC00000, 32'h3FC00000);
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin failed++; $display("FAIL rc_grant got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b0 || bus.resp_id !== 2'd0 || bus.resp_result !== 32'h0) begin failed++; $display("FAIL rc_clear ready=%b valid=%b id=%0d res=%h exp all 0", bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_result); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (bus.resp_valid !== 1'b0) begin failed++; $display("FAIL rc_noresp%0d got=%b exp=0", k, bus.resp_valid); end
    end
    bus.req_valid = 4'b1100;
    #1;
    tests++; if (bus.req_ready !== 4'b0100) begin failed++; $display("FAIL rc_ptr0 got=%b exp=0100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd2 || bus.resp_result !== 32'h40C00000) begin failed++; $display("FAIL rc_resp valid=%b id=%0d res=%h exp 1/2/40c00000", bus.resp_valid, bus.resp_id, bus.resp_result); end
    $display("[TB] reset_calc: dropped in-flight, next id=%0d res=%h", bus.resp_id, bus.resp_result);
    tick();
  endtask

  task automatic test_fair_gap();
    set_ops(0, 32'h40000000, 32'h40400000);
    set_ops(1, 32'h3F800000, 32'h40000000);
    set_ops(3, 32'h3FC00000, 32'h3FC00000);
    bus.req_valid  = 4'b0010;
    bus.resp_ready = 1'b1;
    #1;
    tests++; if (bus.req_ready !== 4'b0010) begin failed++; $display("FAIL gap_grant1 got=%b exp=0010", bus.req_ready); end
    tick();
    bus.req_valid = 4'b1001;
    tick();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1 || bus.resp_result !== 32'h40000000 || bus.req_ready !== 4'b0000) begin failed++; $display("FAIL gap_resp1 valid=%b id=%0d res=%h ready=%b exp 1/1/40000000/0000", bus.resp_valid, bus.resp_id, bus.resp_result, bus.req_ready); end
    tick();
    tests++; if (bus.req_ready !== 4'b1000) begin failed++; $display("FAIL gap_grant3 got=%b exp=1000", bus.req_ready); end
    tick();
    tick();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd3 || bus.resp_result !== 32'h40100000) begin failed++; $display("FAIL gap_resp3 valid=%b id=%0d res=%h exp 1/3/40100000", bus.resp_valid, bus.resp_id, bus.resp_result); end
    tick();
    tests++; if (bus.req_ready !== 4'b0001) begin failed++; $display("FAIL gap_grant0 got=%b exp=0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    tick();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd0 || bus.resp_result !== 32'h40C00000) begin failed++; $display("FAIL gap_resp0 valid=%b id=%0d res=%h exp 1/0/40c00000", bus.resp_valid, bus.resp_id, bus.resp_result); end
    $display("[TB] fair_gap: order 1,3,0 last res=%h", bus.resp_result);
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_calc();
    test_fair_gap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
